axis_eth_tx_arbiter: RTL and testbench
======================================

Name: axis_eth_tx_arbiter

Overview:
- Frame-level round-robin arbiter that shares the single management Ethernet MAC TX AXI-Stream (32-bit, USER_WIDTH 1) between NUM_PORTS frame sources, e.g. the APB software TX buffer and hardware responders.
- Sits between the TX buffers and the RGMII MAC wrapper, in the TX clock domain.
- Never interleaves frames. While the link is down it drains and discards frames so sources never stall.

Parameters:
- NUM_PORTS, 2: number of upstream frame sources (2..8).
- DATA_WIDTH, 32: tdata width in bits. Only 32 is supported; any other value is a synthesis error.

Ports:
- clk  in  1  TX clock (125 MHz); all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- link_up  in  1  MAC link state, already synchronized to clk.
- s_tvalid  in  NUM_PORTS  per-source tvalid.
- s_tready  out  NUM_PORTS  per-source tready.
- s_tdata  in  NUM_PORTS*32  source i occupies bits [32*i+31:32*i].
- s_tkeep  in  NUM_PORTS*4  per-source byte enables.
- s_tlast  in  NUM_PORTS  per-source end of frame.
- s_tuser  in  NUM_PORTS  per-source error flag.
- m_tvalid  out  1  to MAC.
- m_tready  in  1  from MAC.
- m_tdata  out  32  to MAC.
- m_tkeep  out  4  to MAC.
- m_tlast  out  1  to MAC.
- m_tuser  out  1  to MAC.
- grant  out  NUM_PORTS  one-hot; identifies the port owning the current frame (forward or drop).
- frames_sent  out  16  count of frames forwarded; wraps.
- frames_dropped  out  16  count of frames discarded while link down; wraps.

Behaviour:
- States are IDLE, FORWARD and DROP.
- Reset:
  - State goes to IDLE.
  - Round-robin pointer goes to 0.
  - grant = 0, s_tready = 0, m_tvalid = 0.
  - m_tdata, m_tkeep, m_tlast and m_tuser all go to 0.
  - Both counters go to 0.
  - Reset asserted mid-frame abandons the frame immediately, with no tlast emitted. The MAC is responsible for treating the truncated frame as a runt.
- IDLE:
  - Scan s_tvalid starting at the pointer index, wrapping modulo NUM_PORTS. The first asserted port wins.
  - The winner is registered into grant on that edge.
  - Next state is FORWARD if link_up = 1, else DROP.
  - With no tvalid asserted, stay in IDLE with grant = 0.
  - Arbitration costs exactly 1 idle cycle between frames.
- FORWARD:
  - Pure combinational pass-through of the granted port: m_tvalid/tdata/tkeep/tlast/tuser take the granted source's values.
  - s_tready[g] = m_tready; every other s_tready = 0.
  - Zero added latency and no buffering.
  - When m_tvalid && m_tready && m_tlast: increment frames_sent, set pointer = g+1 mod NUM_PORTS, clear grant, return to IDLE.
  - A link_up fall mid-frame does not abort; the frame is forwarded through tlast.
- DROP:
  - m_tvalid = 0; s_tready[g] = 1; every other s_tready = 0.
  - Beats are consumed and discarded.
  - On an accepted beat with tlast: increment frames_dropped, advance the pointer as in FORWARD, return to IDLE.
  - A link_up rise mid-frame does not switch to FORWARD; the rest of the frame is still dropped.
- Outside FORWARD, m_tdata/tkeep/tlast/tuser are driven 0.
- A source that deasserts tvalid mid-frame keeps ownership; the arbiter waits indefinitely and never times out.
- Single-beat frames (tvalid and tlast on the first beat) are legal: IDLE → FORWARD → IDLE, costing 2 cycles when m_tready = 1.
- Counter arithmetic is 16-bit modulo; 0xFFFF + 1 = 0x0000.
- AXI-Stream rule: once the granted source asserts tvalid it must hold the beat until accepted. The arbiter never changes grant while a beat is pending.

Test Plan:
1. Reset, link_up = 1, port 0 sends a 4-beat frame with data 0xA0..0xA3 and m_tready = 1 → after 1 idle cycle, m_tdata = A0, A1, A2, A3 on consecutive cycles; m_tlast on A3; frames_sent = 1; grant returns to 0.
2. Both ports hold tvalid continuously, each sending 3-beat frames, link up → frames alternate 0, 1, 0, 1. No beat from port 1 ever appears inside a port-0 frame. Each gap is exactly 1 cycle.
3. Backpressure: m_tready toggles 1,0,1,0 during a port-1 frame → s_tready[1] mirrors m_tready; s_tready[0] = 0 throughout. Output data is unchanged while m_tready = 0.
4. link_up = 0, port 0 sends a 5-beat frame → s_tready[0] = 1 for 5 cycles; m_tvalid stays 0; frames_dropped = 1. link_up rising on beat 3 still drops the whole frame.
5. link_up falls on beat 2 of 6 in FORWARD → all 6 beats reach the MAC with tlast on beat 6; frames_sent increments.
6. Assert rst on beat 2 of a port-1 frame → next cycle grant = 0, s_tready = 0, m_tvalid = 0, counters = 0. The next frame arbitration starts from port 0.

Source files
------------

// File: rtl/axis_eth_tx_arbiter.sv
// axis_eth_tx_arbiter: frame-level round-robin AXI-Stream arbiter feeding the MAC TX path, dropping frames while the link is down
module axis_eth_tx_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              link_up,
  input  logic [NUM_PORTS-1:0]              s_tvalid,
  output logic [NUM_PORTS-1:0]              s_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_tkeep,
  input  logic [NUM_PORTS-1:0]              s_tlast,
  input  logic [NUM_PORTS-1:0]              s_tuser,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic [DATA_WIDTH-1:0]             m_tdata,
  output logic [DATA_WIDTH/8-1:0]           m_tkeep,
  output logic                              m_tlast,
  output logic                              m_tuser,
  output logic [NUM_PORTS-1:0]              grant,
  output logic [15:0]                       frames_sent,
  output logic [15:0]                       frames_dropped
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int KW = DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, FORWARD, DROP} state_t;
  state_t state, state_nx;
  logic [PW-1:0] ptr, gidx, win_idx, j;
  logic win_found, fwd, drp, acc, done;
  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("axis_eth_tx_arbiter supports only DATA_WIDTH = 32");
  end
  always_comb begin
    win_found = 1'b0;
    win_idx = '0;
    j = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      j = PW'((int'(ptr) + i) % NUM_PORTS);
      if (s_tvalid[j]) begin
        win_found = 1'b1;
        win_idx = j;
      end
    end
  end
  assign fwd      = state == FORWARD;
  assign drp      = state == DROP;
  assign s_tready = fwd ? (grant & {NUM_PORTS{m_tready}}) : drp ? grant : '0;
  assign m_tvalid = fwd & s_tvalid[gidx];
  assign m_tdata  = fwd ? s_tdata[gidx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign m_tkeep  = fwd ? s_tkeep[gidx*KW +: KW] : '0;
  assign m_tlast  = fwd & s_tlast[gidx];
  assign m_tuser  = fwd & s_tuser[gidx];
  assign acc      = s_tvalid[gidx] & s_tready[gidx];
  assign done     = acc & s_tlast[gidx];
  always_comb begin
    state_nx = state;
    if (state == IDLE)
      state_nx = !win_found ? IDLE : link_up ? FORWARD : DROP;
    else if (done)
      state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= '0;
      gidx           <= '0;
      grant          <= '0;
      frames_sent    <= '0;
      frames_dropped <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && win_found) begin
        grant <= NUM_PORTS'(1) << win_idx;
        gidx  <= win_idx;
      end
      if (state != IDLE && done) begin
        grant          <= '0;
        ptr            <= (gidx == PW'(NUM_PORTS - 1)) ? '0 : gidx + 1'b1;
        frames_sent    <= fwd ? frames_sent + 16'd1 : frames_sent;
        frames_dropped <= drp ? frames_dropped + 16'd1 : frames_dropped;
      end
    end
  end
endmodule

// File: tb/tb_axis_eth_tx_arbiter.sv
// tb_axis_eth_tx_arbiter: directed stimulus with a scoreboard queue checked by an output monitor
module tb_axis_eth_tx_arbiter;
  localparam int NP = 2;
  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        u;
  } beat_t;
  logic clk = 0, rst = 1, link_up = 1, m_tready = 1;
  logic [NP-1:0] s_tvalid, s_tready, s_tlast, s_tuser, grant;
  logic [NP*32-1:0] s_tdata;
  logic [NP*4-1:0] s_tkeep;
  logic m_tvalid, m_tlast, m_tuser;
  logic [31:0] m_tdata;
  logic [3:0] m_tkeep;
  logic [15:0] frames_sent, frames_dropped;
  logic v[NP], l[NP], u[NP];
  logic [31:0] d[NP];
  logic [3:0] k[NP];
  beat_t exp_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, last_cyc = 0, rdy0_tot = 0, mv_tot = 0;
  logic gap_chk = 0, bp_chk = 0, gap_arm = 0, in_frame = 0, stall = 0;
  logic [31:0] hold_d;
  int rdy_a, mv_a;
  always #5 clk = ~clk;
  axis_eth_tx_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .link_up(link_up),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tuser(m_tuser),
    .grant(grant), .frames_sent(frames_sent), .frames_dropped(frames_dropped)
  );
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      s_tvalid[i]       = v[i];
      s_tdata[32*i +: 32] = d[i];
      s_tkeep[4*i +: 4]   = k[i];
      s_tlast[i]        = l[i];
      s_tuser[i]        = u[i];
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  task automatic push_frame(input logic [31:0] base, input int n, input logic ul);
    for (int b = 0; b < n; b++)
      exp_q.push_back('{base + b, (b == n - 1) ? 4'h7 : 4'hF, b == n - 1, ul && (b == n - 1)});
  endtask
  task automatic wait_hs(input int p);
    logic hs = 0;
    int t = 0;
    while (!hs) begin
      @(negedge clk);
      hs = s_tready[p];
      @(posedge clk);
      #1;
      if (!hs && ++t > 200) begin
        n_chk++;
        n_fail++;
        $display("FAIL handshake_timeout port %0d: got no tready expected tready within 200 cycles", p);
        hs = 1;
      end
    end
  endtask
  task automatic send(input int p, input int n, input logic [31:0] base, input logic ul);
    for (int b = 0; b < n; b++) begin
      v[p] = 1;
      d[p] = base + b;
      k[p] = (b == n - 1) ? 4'h7 : 4'hF;
      l[p] = b == n - 1;
      u[p] = ul && (b == n - 1);
      wait_hs(p);
    end
    v[p] = 0; d[p] = 0; k[p] = 0; l[p] = 0; u[p] = 0;
  endtask
  always @(negedge clk) begin
    cyc++;
    if (s_tready[0]) rdy0_tot++;
    if (m_tvalid) mv_tot++;
    if (rst) begin
      stall = 0;
      in_frame = 0;
      gap_arm = 0;
    end else begin
      if (m_tvalid && stall) chk("hold_data", m_tdata, hold_d);
      if (m_tvalid && !in_frame && gap_chk && gap_arm) chk("frame_gap", 32'(cyc - last_cyc), 32'd2);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h expected no beat", m_tdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("tdata", m_tdata, e.d);
          chk("tkeep", 32'(m_tkeep), 32'(e.k));
          chk("tlast", 32'(m_tlast), 32'(e.l));
          chk("tuser", 32'(m_tuser), 32'(e.u));
        end
        stall = 0;
        in_frame = !m_tlast;
        if (m_tlast) begin
          last_cyc = cyc;
          gap_arm = gap_chk;
        end
      end else begin
        stall = m_tvalid;
        hold_d = m_tdata;
      end
      if (bp_chk && grant[1]) chk("s_tready_bp", 32'(s_tready), 32'({m_tready, 1'b0}));
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < NP; i++) begin
      v[i] = 0; d[i] = 0; k[i] = 0; l[i] = 0; u[i] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_s_tready", 32'(s_tready), 0);
    chk("rst_m_tvalid", 32'(m_tvalid), 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_sent", 32'(frames_sent), 0);
    @(posedge clk); #1;
    rst = 0;
    push_frame(32'hA0, 4, 0);
    send(0, 4, 32'hA0, 0);
    @(negedge clk);
    chk("t1_grant_clear", 32'(grant), 0);
    chk("t1_sent", 32'(frames_sent), 1);
    @(posedge clk); #1;
    gap_chk = 1;
    push_frame(32'h1100, 3, 0);
    push_frame(32'h0100, 3, 0);
    push_frame(32'h1110, 3, 0);
    push_frame(32'h0110, 3, 0);
    fork
      begin send(0, 3, 32'h0100, 0); send(0, 3, 32'h0110, 0); end
      begin send(1, 3, 32'h1100, 0); send(1, 3, 32'h1110, 0); end
    join
    gap_chk = 0;
    chk("t2_sent", 32'(frames_sent), 5);
    @(posedge clk); #1;
    bp_chk = 1;
    push_frame(32'h1200, 4, 1);
    fork
      send(1, 4, 32'h1200, 1);
      repeat (16) begin @(posedge clk); #1; m_tready = ~m_tready; end
    join
    m_tready = 1;
    bp_chk = 0;
    chk("t3_sent", 32'(frames_sent), 6);
    @(posedge clk); #1;
    link_up = 0;
    rdy_a = rdy0_tot;
    mv_a = mv_tot;
    fork
      send(0, 5, 32'h0300, 0);
      begin repeat (3) @(posedge clk); #1; link_up = 1; end
    join
    chk("t4_tready_cycles", 32'(rdy0_tot - rdy_a), 5);
    chk("t4_no_m_tvalid", 32'(mv_tot - mv_a), 0);
    chk("t4_dropped", 32'(frames_dropped), 1);
    chk("t4_sent", 32'(frames_sent), 6);
    @(posedge clk); #1;
    push_frame(32'h0400, 6, 1);
    fork
      send(0, 6, 32'h0400, 1);
      begin repeat (2) @(posedge clk); #1; link_up = 0; end
    join
    link_up = 1;
    chk("t5_sent", 32'(frames_sent), 7);
    chk("t5_dropped", 32'(frames_dropped), 1);
    @(posedge clk); #1;
    exp_q.push_back('{32'hB0, 4'hF, 1'b0, 1'b0});
    v[1] = 1; d[1] = 32'hB0; k[1] = 4'hF; l[1] = 0; u[1] = 0;
    wait_hs(1);
    d[1] = 32'hB1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    v[1] = 0; d[1] = 0; k[1] = 0;
    @(negedge clk);
    chk("t6_grant", 32'(grant), 0);
    chk("t6_s_tready", 32'(s_tready), 0);
    chk("t6_m_tvalid", 32'(m_tvalid), 0);
    chk("t6_sent", 32'(frames_sent), 0);
    chk("t6_dropped", 32'(frames_dropped), 0);
    @(posedge clk); #1;
    push_frame(32'h0500, 2, 0);
    push_frame(32'h1500, 2, 0);
    fork
      send(0, 2, 32'h0500, 0);
      send(1, 2, 32'h1500, 0);
    join
    chk("t6_sent_after", 32'(frames_sent), 2);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
